serial_logic_unit: RTL

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/serial_logic_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: accepts one operation, produces one result bit
// per clock LSB first, then holds the result under a valid/ready handshake.
module serial_logic_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [2:0]       op_reg;
  logic [CW-1:0]    cnt;

  logic a_bit, b_bit, bit_val;
  logic not_y, and_y, or_y, nand_y, nor_y, xor_y, xnor_y;

  assign a_bit = a_reg[cnt];
  assign b_bit = b_reg[cnt];

  // One gate cell per operation; the registered opcode picks which one feeds the result.
  assign not_y  = ~a_bit;
  assign and_y  = a_bit & b_bit;
  assign or_y   = a_bit | b_bit;
  assign nand_y = ~(a_bit & b_bit);
  assign nor_y  = ~(a_bit | b_bit);
  assign xor_y  = a_bit ^ b_bit;
  assign xnor_y = ~(a_bit ^ b_bit);

  always_comb begin
    bit_val = 1'b0;
    case (op_reg)
      OP_NOT:  bit_val = not_y;
      OP_AND:  bit_val = and_y;
      OP_OR:   bit_val = or_y;
      OP_NAND: bit_val = nand_y;
      OP_NOR:  bit_val = nor_y;
      OP_XOR:  bit_val = xor_y;
      OP_XNOR: bit_val = xnor_y;
      default: bit_val = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            op_reg  <= opcode;
            res_reg <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_reg[cnt] <= bit_val;
          // Counter parks on the last index instead of wrapping.
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_reg;
  // Flags are qualified by out_valid so they read 0 outside DONE.
  assign zero      = out_valid && (res_reg == '0);
  assign err       = out_valid && (op_reg == OP_ILL);

endmodule
